// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared FSM states, LFSR constants and stall counter width for mem_stall_bridge
package mem_bridge_pkg;
  typedef enum logic [1:0] {IDLE, STALL, ACCESS, DONE} state_t;
  localparam logic [7:0] LFSR_POLY = 8'hB8;
  localparam int CNT_W = 8;
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? LFSR_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/stall_lfsr.sv
// stall_lfsr: 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) that advances when en is high
module stall_lfsr
  import mem_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] value
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) value <= seed;
    else if (en) value <= lfsr_step(value);
endmodule

// File: rtl/mem_stall_bridge.sv
// mem_stall_bridge: registers CPU requests, inserts waitrequest stalls, issues one RAM access per request.
// Define STALL_LFSR_EN to draw the per-transaction stall from an LFSR instead of STALL_CYCLES.
module mem_stall_bridge
  import mem_bridge_pkg::*;
#(
  parameter logic [7:0] STALL_CYCLES = 8'd2,
  parameter logic [7:0] STALL_MASK   = 8'h07,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_active,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_byteenable,
  input  logic [31:0] cpu_writedata,
  output logic        cpu_waitrequest,
  output logic [31:0] cpu_readdata,
  output logic        mem_active,
  output logic [31:0] mem_address,
  output logic        mem_read_en,
  output logic        mem_wr_en,
  output logic [3:0]  mem_byte_en,
  output logic        mem_waitrequest,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        bus_err,
  output logic [31:0] txn_count
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, stall;
  logic wr_q;
  logic [31:0] rd_q;
  logic req, accept;
  assign req = cpu_read | cpu_write;
  assign accept = (state == IDLE) & req;
`ifdef STALL_LFSR_EN
  logic [7:0] lfsr;
  logic unused_cfg;
  assign unused_cfg = ^STALL_CYCLES;
  stall_lfsr u_lfsr (.clk(clk), .reset_n(reset_n), .en(accept), .seed(LFSR_SEED), .value(lfsr));
  // the stall is taken from the value the LFSR advances to on this accept
  assign stall = lfsr_step(lfsr) & STALL_MASK;
`else
  logic unused_cfg;
  assign unused_cfg = ^{STALL_MASK, LFSR_SEED};
  assign stall = STALL_CYCLES;
`endif
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = req ? ((stall != '0) ? STALL : ACCESS) : IDLE;
      STALL:   state_nx = (cnt == CNT_W'(1)) ? ACCESS : STALL;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      mem_address <= '0;
      mem_byte_en <= '0;
      mem_data_in <= '0;
      mem_active  <= 1'b1;
      bus_err     <= 1'b0;
      txn_count   <= '0;
    end else begin
      state      <= state_nx;
      bus_err    <= bus_err | (cpu_read & cpu_write);
      // a falling cpu_active waits for the bus to drain before reaching the RAM
      mem_active <= cpu_active | (mem_active & ~((state == IDLE) & ~req));
      if (accept) begin
        mem_address <= cpu_address;
        mem_byte_en <= cpu_byteenable;
        mem_data_in <= cpu_writedata;
        wr_q        <= cpu_write;
        cnt         <= stall;
      end else if (state == STALL) cnt <= cnt - CNT_W'(1);
      if (state == DONE) begin
        txn_count <= txn_count + 32'd1;
        if (!wr_q) rd_q <= mem_data_out;
      end
    end
  assign cpu_waitrequest = req & (state != DONE);
  assign cpu_readdata    = ((state == DONE) & ~wr_q) ? mem_data_out : rd_q;
  assign mem_read_en     = (state == ACCESS) & ~wr_q;
  assign mem_wr_en       = (state == ACCESS) & wr_q;
  assign mem_waitrequest = state != ACCESS;
endmodule

// File: tb/tb_mem_stall_bridge.sv
// tb_mem_stall_bridge: randomized scoreboard bench for mem_stall_bridge with a byte RAM and reference memory
module tb_mem_stall_bridge;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic cpu_active = 1'b1;
  logic [31:0] cpu_address = '0;
  logic cpu_read = 1'b0, cpu_write = 1'b0;
  logic [3:0] cpu_byteenable = '0;
  logic [31:0] cpu_writedata = '0;
  logic cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic mem_active;
  logic [31:0] mem_address;
  logic mem_read_en, mem_wr_en;
  logic [3:0] mem_byte_en;
  logic mem_waitrequest;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic bus_err;
  logic [31:0] txn_count;

  mem_stall_bridge #(.STALL_CYCLES(8'd2), .STALL_MASK(8'h07), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_active(cpu_active), .cpu_address(cpu_address),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_byteenable(cpu_byteenable),
    .cpu_writedata(cpu_writedata), .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .mem_active(mem_active), .mem_address(mem_address), .mem_read_en(mem_read_en),
    .mem_wr_en(mem_wr_en), .mem_byte_en(mem_byte_en), .mem_waitrequest(mem_waitrequest),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .bus_err(bus_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM seen by the DUT: byte addressed, registered read data
  logic [7:0] ram [int unsigned];
  function automatic logic [7:0] ramb(input int unsigned a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction
  always @(posedge clk) begin
    if (mem_wr_en && !mem_waitrequest)
      for (int i = 0; i < 4; i++) if (mem_byte_en[i]) ram[mem_address + i] = mem_data_in[8*i +: 8];
    if (mem_read_en)
      mem_data_out <= {ramb(mem_address + 3), ramb(mem_address + 2), ramb(mem_address + 1), ramb(mem_address)};
  end

  // reference model state
  logic [7:0] mdl [int unsigned];
  function automatic logic [31:0] mdl_word(input int unsigned a);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mdl.exists(a + i) ? mdl[a + i] : 8'h00;
    return w;
  endfunction
  function automatic logic [7:0] lstep(input logic [7:0] v);
    logic [7:0] r = v >> 1;
    if (v[0]) r = r ^ 8'hB8;
    return r;
  endfunction

  typedef struct {
    int start; int n; bit rd; bit err;
    logic [31:0] addr; logic [3:0] be; logic [31:0] data; logic [31:0] rdata; logic [31:0] cnt;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  logic [7:0] lfsr_m = 8'hA5;
  bit exp_err = 0;
  logic [31:0] last_rd = '0;
  logic [31:0] issued = '0;
  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (reset_n) begin
    if (mem_wr_en || mem_read_en) begin
      if (sbq.size() == 0) chk("stray_strobe", 32'd1, 32'd0);
      else begin
        mon_e = sbq[0];
        chk("strobe_cycle", cyc, mon_e.start + mon_e.n + 1);
        chk("strobe_op", {31'd0, mem_wr_en}, {31'd0, !mon_e.rd});
        chk("mem_waitrequest", {31'd0, mem_waitrequest}, 32'd0);
        chk("mem_address", mem_address, mon_e.addr);
        chk("mem_byte_en", {28'd0, mem_byte_en}, {28'd0, mon_e.be});
        if (!mon_e.rd) chk("mem_data_in", mem_data_in, mon_e.data);
      end
    end
    if ((cpu_read || cpu_write) && !cpu_waitrequest) begin
      if (sbq.size() == 0) chk("stray_done", 32'd1, 32'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("latency", cyc, mon_e.start + mon_e.n + 2);
        chk("cpu_readdata", cpu_readdata, mon_e.rdata);
        chk("txn_count", txn_count, mon_e.cnt);
        chk("bus_err", {31'd0, bus_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic txn(input bit rd, input bit both, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] d, input int gap);
    exp_t e;
    bit done = 0;
`ifdef STALL_LFSR_EN
    lfsr_m = lstep(lfsr_m);
    e.n = int'(lfsr_m & 8'h07);
`else
    e.n = 2;
`endif
    e.start = cyc; e.rd = rd && !both; e.addr = a; e.be = be; e.data = d;
    if (e.rd) begin
      e.rdata = mdl_word(a);
      last_rd = e.rdata;
    end else begin
      e.rdata = last_rd;
      for (int i = 0; i < 4; i++) if (be[i]) mdl[a + i] = d[8*i +: 8];
    end
    exp_err = exp_err | both;
    e.err = exp_err; e.cnt = issued; issued++;
    sbq.push_back(e);
    cpu_read = rd | both; cpu_write = !rd | both;
    cpu_address = a; cpu_byteenable = be; cpu_writedata = d;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) done = 1;
      else begin
        @(posedge clk); #1;
        // payload changes while stalled must be ignored
        if ($urandom_range(0, 1) == 1) cpu_address = $urandom;
        if ($urandom_range(0, 1) == 1) cpu_writedata = $urandom;
        if ($urandom_range(0, 1) == 1) cpu_byteenable = 4'($urandom);
      end
    end
    if (!done) chk("completion_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_read = 0; cpu_write = 0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic preload(input int unsigned a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin ram[a + i] = w[8*i +: 8]; mdl[a + i] = w[8*i +: 8]; end
  endtask

  task automatic do_reset;
    reset_n = 0; cpu_read = 0; cpu_write = 0;
    sbq.delete(); lfsr_m = 8'hA5; exp_err = 0; last_rd = '0; issued = '0;
    #1;
    chk("rst_cpu_waitrequest", {31'd0, cpu_waitrequest}, 32'd0);
    chk("rst_cpu_readdata", cpu_readdata, 32'd0);
    chk("rst_mem_active", {31'd0, mem_active}, 32'd1);
    chk("rst_mem_waitrequest", {31'd0, mem_waitrequest}, 32'd1);
    chk("rst_strobes", {30'd0, mem_read_en, mem_wr_en}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_byte_en", {28'd0, mem_byte_en}, 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_txn_count", txn_count, 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    #2;
    do_reset;
    @(posedge clk); #1;
    txn(0, 0, 32'h10, 4'hF, 32'hDEADBEEF, 1);
    chk("ram_10", {ramb(32'h13), ramb(32'h12), ramb(32'h11), ramb(32'h10)}, 32'hDEADBEEF);
    preload(32'h20, 32'h44332211);
    txn(0, 0, 32'h20, 4'b0100, 32'h00AB0000, 0);
    chk("ram_20", {ramb(32'h23), ramb(32'h22), ramb(32'h21), ramb(32'h20)}, 32'h44AB2211);
    preload(32'hBFC00000, 32'h2402000A);
    txn(1, 0, 32'hBFC00000, 4'hF, 32'h0, 2);
    txn(0, 1, 32'h30, 4'hF, 32'h12345678, 0);
    chk("bus_err_set", {31'd0, bus_err}, 32'd1);
    for (int k = 0; k < 60; k++) begin
      w = ($urandom_range(0, 3) == 0) ? 32'hBFC00000 : 32'h0;
      w = w | {24'd0, 6'($urandom), 2'b00};
      txn($urandom_range(0, 1) == 1, 0, w, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 2));
    end
    fork
      txn(0, 0, 32'h50, 4'hF, 32'hCAFEF00D, 0);
      begin @(posedge clk); #2; cpu_active = 0; end
    join
    chk("mem_active_held", {31'd0, mem_active}, 32'd1);
    chk("ram_50", {ramb(32'h53), ramb(32'h52), ramb(32'h51), ramb(32'h50)}, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("mem_active_fall", {31'd0, mem_active}, 32'd0);
    cpu_active = 1;
    @(posedge clk); #1;
    chk("mem_active_rise", {31'd0, mem_active}, 32'd1);
    w = mdl_word(32'h40);
    cpu_write = 1; cpu_address = 32'h40; cpu_byteenable = 4'hF; cpu_writedata = ~w;
    @(posedge clk); #2;
    do_reset;
    repeat (6) @(posedge clk);
    #1;
    chk("ram_40_untouched", {ramb(32'h43), ramb(32'h42), ramb(32'h41), ramb(32'h40)}, w);
    txn(1, 0, 32'h50, 4'hF, 32'h0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_stall_bridge.md
Name: mem_stall_bridge

Overview:
- Sits between the CPU's Avalon-style data/instruction master and the test-bench byte-addressed RAM model.
- Registers each CPU request and injects a programmable number of waitrequest stall cycles.
- Issues exactly one single-cycle access to the RAM and returns read data to the CPU.
- Gates the RAM's end-of-simulation "active" signal so the final memory dump never races an in-flight write.

Parameters:
- STALL_CYCLES, 2, fixed stall cycles inserted per transaction (0..255).
- STALL_MASK, 8'h07, mask applied to the LFSR value when STALL_LFSR_EN is defined.
- LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_active  in  1  CPU running flag.
- cpu_address  in  32  byte address; passed to the RAM unaltered, since the RAM applies the 0xBFC00000 remap itself.
- cpu_read  in  1  read request.
- cpu_write  in  1  write request.
- cpu_byteenable  in  4  byte lanes.
- cpu_writedata  in  32  write data.
- cpu_waitrequest  out  1  stall to CPU.
- cpu_readdata  out  32  read data, valid in the completion cycle.
- mem_active  out  1  active to RAM.
- mem_address  out  32  latched address.
- mem_read_en  out  1  RAM read strobe.
- mem_wr_en  out  1  RAM write strobe.
- mem_byte_en  out  4  latched byte enables.
- mem_waitrequest  out  1  RAM write inhibit.
- mem_data_in  out  32  latched write data.
- mem_data_out  in  32  registered RAM read data.
- bus_err  out  1  sticky protocol error flag.
- txn_count  out  32  completed transactions, wraps.

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE, stall counter 0, LFSR=LFSR_SEED.
  - mem_active=1, mem_waitrequest=1.
  - mem_read_en=0, mem_wr_en=0, mem_address/mem_byte_en/mem_data_in=0.
  - cpu_readdata=0, bus_err=0, txn_count=0.
  - A transaction in flight is aborted. A write not yet past the ACCESS edge never reaches the RAM.
- State machine (states IDLE, STALL, ACCESS, DONE):
  - IDLE:
    - With cpu_read|cpu_write high: latch address, byteenable, writedata and op; load counter = stall value.
    - Go to STALL if stall value > 0, else ACCESS.
  - STALL: decrement the counter; go to ACCESS when the counter reaches 1.
  - ACCESS: mem_read_en or mem_wr_en=1 and mem_waitrequest=0 for exactly this cycle. Always go to DONE.
  - DONE:
    - cpu_waitrequest=0.
    - cpu_readdata = mem_data_out (reads); cpu_readdata holds its previous value on writes.
    - txn_count increments.
    - Go to IDLE.
- Latency:
  - With request first asserted in cycle 0, the completion (waitrequest low) cycle is N+2, where N is the stall value.
  - The RAM write commits at the end of cycle N+1.
- cpu_waitrequest = (cpu_read|cpu_write) & (state != DONE). It is combinational, with no idle-bus stall.
- Request changes while stalled are ignored; only the values latched in IDLE are used.
- cpu_read & cpu_write in the same cycle: treated as a write and sets bus_err (sticky until reset).
- mem_waitrequest = 1 in every state except ACCESS.
- mem_active:
  - Rises with cpu_active on the next edge.
  - A fall of cpu_active is deferred until state==IDLE with no pending request. Then mem_active=0 on the next edge.
- txn_count is 32-bit modulo; 0xFFFFFFFF+1 = 0.

Optional Feature:
- STALL_LFSR_EN defined:
  - Stall value = lfsr & STALL_MASK.
  - 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - Advances once per accepted request in IDLE.
  - STALL_CYCLES is unused.
- STALL_LFSR_EN undefined: stall value = STALL_CYCLES for every transaction; the LFSR is absent.

Decomposition:
- Package mem_bridge_pkg: state enum (IDLE, STALL, ACCESS, DONE), LFSR polynomial constant 8'hB8, stall counter width 8.
- One sub-module: stall_lfsr (enable, seed, 8-bit value), instantiated only under STALL_LFSR_EN.

Test Plan:
- STALL_CYCLES=2. Write 0xDEADBEEF to 0x00000010, byteenable 4'hF, asserted in cycle 0 -> mem_wr_en high only in cycle 3; cpu_waitrequest low in cycle 4; RAM bytes 0x10..0x13 = EF,BE,AD,DE; txn_count=1.
- STALL_CYCLES=0. Read 0xBFC00000 after the RAM is preloaded with 0x2402000A -> cpu_waitrequest low in cycle 2 with cpu_readdata=0x2402000A.
- Byteenable 4'b0100 write of 0x00AB0000 to 0x20 -> only RAM byte 0x22=AB changes; mem_wr_en high for exactly one cycle.
- cpu_read=cpu_write=1 -> treated as a write; bus_err=1 and stays 1 across later clean transactions.
- cpu_active falls during STALL of a write -> write commits; mem_active falls only on the edge after DONE.
- reset_n pulsed low during STALL -> mem_wr_en never asserts, outputs at reset values, state IDLE. With STALL_LFSR_EN and seed 0xA5, the first stall is (0xA5 advanced once) & 0x07, checked against a bench model.
